// File: rtl/sssp_update_packer_if.sv
`default_nettype none
// ============================================================================
// Interface : sssp_update_packer_if
// Update-lane input bus and packed-line output bus of the SSSP update packer.
// Rev       : 1.0
// ============================================================================
interface sssp_update_packer_if;
   logic [3:0][63:0] upd_in;
   logic [3:0]       upd_valid;
   logic             last_input_in;
   logic             almost_full;
   logic [511:0]     line_out;
   logic             line_valid;
   logic             line_ready;

   modport master (
      output upd_in, upd_valid, last_input_in, line_ready,
      input  almost_full, line_out, line_valid
   );

   modport slave (
      input  upd_in, upd_valid, last_input_in, line_ready,
      output almost_full, line_out, line_valid
   );
endinterface
`default_nettype wire

// File: rtl/sssp_update_packer.sv
`default_nettype none
// ============================================================================
// Module : sssp_update_packer
// Packs per-lane SSSP updates into dense 512-bit lines behind a line FIFO.
// Option : SSSP_PACKER_STATS_EN builds the upd_count/line_count counters.
// Rev    : 1.0
// ============================================================================
module sssp_update_packer #(
   parameter int FIFO_DEPTH = 8,
   parameter int AF_MARGIN  = 3
) (
   input  wire                 clk,
   input  wire                 rst_n,
   input  wire [1:0]           control,
   sssp_update_packer_if.slave bus,
   output logic                done,
   output logic                overflow,
   output logic [31:0]         upd_count,
   output logic [31:0]         line_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_FLUSH = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int               c_PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [c_PTR_W:0] c_FULL      = (c_PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [c_PTR_W:0] c_AF_LEVEL  = (c_PTR_W + 1)'(FIFO_DEPTH - AF_MARGIN);
   localparam logic [1:0]       c_PHASE_UPD = 2'h2;

   state_t           r_state, w_next;
   logic [7:0][63:0] r_stage, w_stage_nx, w_line, w_carry, w_pad, w_push_line;
   logic [2:0]       r_fill, w_fill_nx;
   logic [3:0][63:0] w_cmp;
   logic [2:0]       w_k;
   logic [3:0]       w_sum;
   logic             w_wrap;

   logic [511:0]       r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wptr, r_rptr;
   logic [c_PTR_W:0]   r_cnt;
   logic               w_full, w_empty, w_pop, w_room, w_push_req, w_push;
   logic               r_af, r_done, r_overflow;

   // Compact valid lanes, then split them across the current and next staging line
   always_comb begin
      logic [3:0] idx;
      idx     = '0;
      w_cmp   = '0;
      w_k     = '0;
      w_line  = r_stage;
      w_carry = '0;
      w_pad   = r_stage;
      for (int i = 0; i < 4; i++) begin
         if (r_state == S_RUN && bus.upd_valid[i]) begin
            w_cmp[w_k[1:0]] = bus.upd_in[i];
            w_k             = w_k + 3'd1;
         end
      end
      w_sum = {1'b0, r_fill} + {1'b0, w_k};
      for (int s = 0; s < 8; s++) begin
         idx = 4'(s) - {1'b0, r_fill};
         if (4'(s) >= {1'b0, r_fill}) begin
            w_pad[s] = '1;
            if (idx < {1'b0, w_k}) w_line[s] = w_cmp[idx[1:0]];
         end
      end
      for (int s = 0; s < 4; s++) begin
         idx = 4'(s) + 4'd8 - {1'b0, r_fill};
         if (idx < {1'b0, w_k}) w_carry[s] = w_cmp[idx[1:0]];
      end
   end

   assign w_wrap  = w_sum[3];
   assign w_full  = (r_cnt == c_FULL);
   assign w_empty = (r_cnt == '0);
   assign w_pop   = !w_empty && bus.line_ready;
   assign w_room  = !w_full || w_pop;
   assign w_push  = w_push_req && w_room;

   always_comb begin
      w_next      = r_state;
      w_push_req  = 1'b0;
      w_push_line = w_line;
      w_stage_nx  = r_stage;
      w_fill_nx   = r_fill;
      case (r_state)
         S_IDLE:  if (control == c_PHASE_UPD) w_next = S_RUN;
         S_RUN: begin
            w_push_req = w_wrap;
            w_stage_nx = w_wrap ? w_carry : w_line;
            w_fill_nx  = w_sum[2:0];
            if (bus.last_input_in) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (r_fill == '0) begin
               w_next = S_DRAIN;
            end else if (w_room) begin
               w_push_req  = 1'b1;
               w_push_line = w_pad;
               w_fill_nx   = '0;
               w_next      = S_DRAIN;
            end
         end
         S_DRAIN: if (w_empty) w_next = S_DONE;
         S_DONE:  if (control != c_PHASE_UPD) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_stage    <= '0;
         r_fill     <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stage <= w_stage_nx;
         r_fill  <= w_fill_nx;
         r_done  <= (w_next == S_DONE);
         if (w_push_req && !w_room) r_overflow <= 1'b1;
      end
   end

   // Storage needs no reset: pointers and the output gate hide stale entries
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_push_line;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_af   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         r_af <= (r_cnt >= c_AF_LEVEL);
      end
   end

   assign bus.line_valid  = !w_empty;
   assign bus.line_out    = w_empty ? '0 : r_mem[r_rptr];
   assign bus.almost_full = r_af;
   assign done            = r_done;
   assign overflow        = r_overflow;

`ifdef SSSP_PACKER_STATS_EN
   logic [31:0] r_upd_count, r_line_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upd_count  <= '0;
         r_line_count <= '0;
      end else if (r_state == S_IDLE && w_next == S_RUN) begin
         r_upd_count  <= '0;
         r_line_count <= '0;
      end else begin
         r_upd_count <= r_upd_count + 32'(w_k);
         if (w_push) r_line_count <= r_line_count + 32'd1;
      end
   end

   assign upd_count  = r_upd_count;
   assign line_count = r_line_count;
`else
   assign upd_count  = '0;
   assign line_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sssp_update_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_sssp_update_packer
// Directed self-checking bench for sssp_update_packer.
// Rev    : 1.0
// ============================================================================
module tb_sssp_update_packer;

`ifdef SSSP_PACKER_STATS_EN
   localparam bit c_STATS = 1'b1;
`else
   localparam bit c_STATS = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [1:0]  control;
   logic        done;
   logic        overflow;
   logic [31:0] upd_count;
   logic [31:0] line_count;

   int n_chk  = 0;
   int n_pass = 0;
   int ids[8];

   sssp_update_packer_if bus ();

   sssp_update_packer #(
      .FIFO_DEPTH (8),
      .AF_MARGIN  (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .control    (control),
      .bus        (bus),
      .done       (done),
      .overflow   (overflow),
      .upd_count  (upd_count),
      .line_count (line_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mk(input int id);
      return {32'(id), 32'(id) ^ 32'hA5A5_0000};
   endfunction

   // First n slots hold the listed ids, remaining slots are null padding
   function automatic logic [511:0] pack(input int id_list[8], input int n);
      logic [511:0] l;
      l = '1;
      for (int k = 0; k < n; k++) l[64*k +: 64] = mk(id_list[k]);
      return l;
   endfunction

   function automatic logic [31:0] ecnt(input int v);
      return c_STATS ? 32'(v) : 32'd0;
   endfunction

   task automatic drive(input logic [3:0] vld, input int base);
      for (int i = 0; i < 4; i++) bus.upd_in[i] = mk(base + i);
      bus.upd_valid = vld;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 20 && !done; i++) tick();
      check(tag, done, 1'b1);
   endtask

   initial begin
      rst_n              = 1'b0;
      control            = 2'h0;
      bus.last_input_in  = 1'b0;
      bus.line_ready     = 1'b1;
      drive(4'h0, 0);
      tick();
      tick();
      check("rst_line_valid", bus.line_valid, 1'b0);
      check("rst_line_out", bus.line_out, '0);
      check("rst_done", done, 1'b0);
      check("rst_almost_full", bus.almost_full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_upd_count", upd_count, 32'd0);
      check("rst_line_count", line_count, 32'd0);
      rst_n = 1'b1;
      tick();

      // Two full-lane cycles make one line, dst 0..7 in order
      control = 2'h2;
      tick();
      drive(4'hF, 0);
      tick();
      check("s1_no_early_line", bus.line_valid, 1'b0);
      drive(4'hF, 4);
      tick();
      drive(4'h0, 0);
      ids = '{0, 1, 2, 3, 4, 5, 6, 7};
      check("s1_line_valid", bus.line_valid, 1'b1);
      check("s1_line", bus.line_out, pack(ids, 8));
      check("s1_upd_count", upd_count, ecnt(8));
      check("s1_line_count", line_count, ecnt(1));
      bus.last_input_in = 1'b1;
      tick();
      bus.last_input_in = 1'b0;
      check("s1_popped", bus.line_valid, 1'b0);
      wait_done("s1_done");
      control = 2'h0;
      tick();
      check("s1_done_clear", done, 1'b0);

      // Sparse lanes then a full cycle: wrap with two updates carried
      control = 2'h2;
      tick();
      check("s2_count_clear", upd_count, 32'd0);
      drive(4'b1010, 0);
      tick();
      drive(4'b1010, 4);
      tick();
      drive(4'b1010, 8);
      tick();
      drive(4'b1111, 12);
      tick();
      drive(4'h0, 0);
      ids = '{1, 3, 5, 7, 9, 11, 12, 13};
      check("s2_line", bus.line_out, pack(ids, 8));
      bus.last_input_in = 1'b1;
      tick();
      bus.last_input_in = 1'b0;
      tick();
      ids = '{14, 15, 0, 0, 0, 0, 0, 0};
      check("s2_pad_valid", bus.line_valid, 1'b1);
      check("s2_pad_line", bus.line_out, pack(ids, 2));
      check("s2_done_low", done, 1'b0);
      check("s2_upd_count", upd_count, ecnt(10));
      check("s2_line_count", line_count, ecnt(2));
      wait_done("s2_done");
      control = 2'h0;
      tick();

      // Five updates then end of stream, with the write path stalled
      control = 2'h2;
      tick();
      drive(4'hF, 20);
      tick();
      drive(4'b0001, 24);
      tick();
      drive(4'h0, 0);
      bus.line_ready    = 1'b0;
      bus.last_input_in = 1'b1;
      tick();
      bus.last_input_in = 1'b0;
      tick();
      ids = '{20, 21, 22, 23, 24, 0, 0, 0};
      check("s3_pad_line", bus.line_out, pack(ids, 5));
      tick();
      tick();
      check("s3_pad_hold", bus.line_out, pack(ids, 5));
      check("s3_done_wait", done, 1'b0);
      check("s3_line_count", line_count, ecnt(1));
      check("s3_upd_count", upd_count, ecnt(5));
      bus.line_ready = 1'b1;
      wait_done("s3_done");
      check("s3_drained", bus.line_valid, 1'b0);
      control = 2'h0;
      tick();

      // Continuous input against a stalled write path until a line drops
      bus.line_ready = 1'b0;
      control        = 2'h2;
      tick();
      for (int j = 1; j <= 18; j++) begin
         drive(4'hF, 100 + 4 * (j - 1));
         tick();
         if (j == 10) check("s4_af_low", bus.almost_full, 1'b0);
         if (j == 11) check("s4_af_high", bus.almost_full, 1'b1);
         if (j == 16) check("s4_no_overflow", overflow, 1'b0);
         if (j == 18) check("s4_overflow", overflow, 1'b1);
      end
      drive(4'h0, 0);
      for (int k = 0; k < 8; k++) ids[k] = 100 + k;
      check("s4_head_hold", bus.line_out, pack(ids, 8));
      check("s4_line_count", line_count, ecnt(8));
      check("s4_upd_count", upd_count, ecnt(72));

      // Asynchronous reset with lines queued
      #3;
      rst_n = 1'b0;
      #1;
      check("s5_async_valid", bus.line_valid, 1'b0);
      check("s5_async_overflow", overflow, 1'b0);
      check("s5_async_af", bus.almost_full, 1'b0);
      control = 2'h0;
      drive(4'hF, 200);
      tick();
      rst_n          = 1'b1;
      bus.line_ready = 1'b1;
      tick();
      check("s5_fifo_empty", bus.line_valid, 1'b0);
      control = 2'h2;
      tick();
      drive(4'hF, 300);
      tick();
      drive(4'hF, 304);
      tick();
      drive(4'h0, 0);
      for (int k = 0; k < 8; k++) ids[k] = 300 + k;
      check("s5_clean_line", bus.line_out, pack(ids, 8));
      check("s5_upd_count", upd_count, ecnt(8));
      bus.last_input_in = 1'b1;
      tick();
      bus.last_input_in = 1'b0;
      wait_done("s5_done");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
